// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between producers, the arbiter and the FIFO.
// master: producers + FIFO flag; slave: the arbiter.
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic [OW-1:0]                 owner;
  logic                          busy;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  gnt, ack, fifo_write, fifo_data, owner, busy
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output gnt, ack, fifo_write, fifo_data, owner, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of the FIFO write port.
// One owner at a time; beats pass combinationally while granted.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input logic clk,
  input logic rst_n,
  fifo_write_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  state_t             state_nx;
  logic [OW-1:0]      ptr;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      sel;
  logic [OW-1:0]      ptr_nx;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_c;
  logic               busy_q;
  logic               found;
  logic               beat;
  logic               rel;
  logic               wr_c;
  logic [DATA_WIDTH-1:0] data_c;
  int                 idx;

  // First asserted request at or above the pointer, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
  end

  assign ptr_nx = (owner_q == OW'(NUM_REQ - 1)) ?
                  '0 : owner_q + 1'b1;

  // Next state and the combinational beat path.
  always_comb begin
    state_nx = state;
    beat     = 1'b0;
    rel      = 1'b0;
    ack_c    = '0;
    wr_c     = 1'b0;
    data_c   = '0;
    unique case (state)
      IDLE: begin
        if (found) state_nx = GRANT;
      end
      GRANT: begin
        beat = bus.req[owner_q] && !bus.fifo_full && rst_n;
        data_c = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        wr_c = beat;
        ack_c[owner_q] = beat;
        rel = !bus.req[owner_q] ||
              (beat && (bus.req_last[owner_q] ||
                        cnt == CW'(BURST_LEN - 1)));
        if (rel) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant, pointer and beat counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      cnt     <= '0;
      ptr     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        gnt_q   <= NUM_REQ'(1) << sel;
        owner_q <= sel;
        busy_q  <= 1'b1;
        cnt     <= '0;
      end else if (rel) begin
        gnt_q  <= '0;
        busy_q <= 1'b0;
        cnt    <= '0;
        ptr    <= ptr_nx;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Structural invariants of the grant/ack/write relationship.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt_q));
      assert (!(wr_c && bus.fifo_full));
      assert ((ack_c & ~gnt_q) == '0);
      assert (wr_c == |ack_c);
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_c;
  assign bus.fifo_write = wr_c;
  assign bus.fifo_data  = data_c;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter.
// NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=8.
module tb_fifo_write_arbiter;
  logic clk;
  logic rst_n;
  int total = 0;
  int bad = 0;

  fifo_write_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  fifo_write_arbiter #(
    .DATA_WIDTH(8),
    .NUM_REQ(4),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] s_ack;
  logic       s_wr;
  logic [7:0] s_data;
  logic       s_busy;
  logic [1:0] s_owner;
  logic [7:0] wq[$];
  int         oseq[$];
  int         ackcnt[4];
  int         cycles;
  int         n;
  logic [7:0] pat;
  logic       pb;

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    s_ack   = bus.ack;
    s_wr    = bus.fifo_write;
    s_data  = bus.fifo_data;
    s_busy  = bus.busy;
    s_owner = bus.owner;
    if (s_wr) wq.push_back(s_data);
    for (int i = 0; i < 4; i++)
      if (s_ack[i]) ackcnt[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(int i, logic [7:0] v);
    bus.req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    bus.req_data  = '0;
    cyc();
    cyc();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_wr", int'(bus.fifo_write), 0);
    rst_n = 1'b1;
    wq.delete();
    oseq.delete();
    for (int i = 0; i < 4; i++) ackcnt[i] = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // single requester, 6 beats, bursts of 4
    do_reset();
    bus.req = 4'b0100;
    n = 0;
    cycles = 0;
    pat = '0;
    while (n < 6 && cycles < 8) begin
      set_data(2, 8'hA0 + 8'(n));
      cyc();
      pat[cycles] = s_wr;
      cycles++;
      if (s_ack[2]) n++;
    end
    chk("t1_beats", n, 6);
    chk("t1_cycles", cycles, 8);
    chk("t1_pattern", int'(pat), 8'hDE);
    chk("t1_nwr", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++)
      chk("t1_data", int'(wq[i]), 8'hA0 + i);
    bus.req = 4'b0000;
    cyc();
    chk("t1_drop_busy", int'(s_busy), 1);
    chk("t1_drop_wr", int'(s_wr), 0);
    bus.req = 4'b1100;
    cyc();
    chk("t1_rel_busy", int'(s_busy), 0);
    chk("t1_ptr_owner", int'(bus.owner), 3);
    chk("t1_ptr_gnt", int'(bus.gnt), 4'b1000);
    bus.req = 4'b0000;
    cyc();
    cyc();

    // round robin with all four requesting
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 * i + 1));
    pb = 1'b0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      if (s_busy && !pb) oseq.push_back(int'(s_owner));
      pb = s_busy;
      if (c == 19) begin
        chk("t2_writes", wq.size(), 16);
        for (int i = 0; i < 4; i++)
          chk("t2_ackcnt", ackcnt[i], 4);
      end
    end
    chk("t2_nseq", oseq.size(), 5);
    for (int i = 0; i < 5 && i < oseq.size(); i++)
      chk("t2_owner_seq", oseq[i], i % 4);
    bus.req = 4'b0000;
    cyc();
    cyc();

    // early last on beat 2
    do_reset();
    bus.req = 4'b0010;
    n = 0;
    cycles = 0;
    while (n < 2 && cycles < 10) begin
      set_data(1, (n == 0) ? 8'h11 : 8'h22);
      bus.req_last[1] = (n == 1);
      cyc();
      cycles++;
      if (s_ack[1]) n++;
    end
    bus.req_last = '0;
    chk("t3_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t3_d0", int'(wq[0]), 8'h11);
      chk("t3_d1", int'(wq[1]), 8'h22);
    end
    bus.req = 4'b0110;
    cyc();
    chk("t3_rel_busy", int'(s_busy), 0);
    chk("t3_rel_wr", int'(s_wr), 0);
    chk("t3_ptr_owner", int'(bus.owner), 2);
    bus.req = 4'b0000;
    cyc();
    cyc();

    // backpressure after beat 1
    do_reset();
    bus.req = 4'b0001;
    set_data(0, 8'hB0);
    cyc();
    chk("t4_idle_wr", int'(s_wr), 0);
    cyc();
    chk("t4_b0_wr", int'(s_wr), 1);
    set_data(0, 8'hB1);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_full_wr", int'(s_wr), 0);
      chk("t4_full_ack", int'(s_ack), 0);
      chk("t4_full_busy", int'(s_busy), 1);
    end
    bus.fifo_full = 1'b0;
    for (int i = 1; i < 4; i++) begin
      set_data(0, 8'(8'hB0 + i));
      cyc();
      chk("t4_beat_wr", int'(s_wr), 1);
      chk("t4_beat_data", int'(s_data), 8'hB0 + i);
    end
    cyc();
    chk("t4_rel_busy", int'(s_busy), 0);
    chk("t4_nwr", wq.size(), 4);
    bus.req = 4'b0000;
    cyc();
    cyc();

    // reset in the middle of owner 3's burst
    do_reset();
    bus.req = 4'b1000;
    set_data(3, 8'hC0);
    cyc();
    cyc();
    cyc();
    chk("t5_pre_owner", int'(bus.owner), 3);
    rst_n = 1'b0;
    cyc();
    chk("t5_rst_wr", int'(s_wr), 0);
    chk("t5_rst_gnt", int'(bus.gnt), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    bus.req = 4'b1001;
    cyc();
    chk("t5_next_owner", int'(bus.owner), 0);
    chk("t5_next_gnt", int'(bus.gnt), 4'b0001);
    bus.req = 4'b0000;
    cyc();
    cyc();

    // owner drops req without last
    do_reset();
    bus.req = 4'b1010;
    set_data(1, 8'hD1);
    set_data(3, 8'hD3);
    cyc();
    cyc();
    chk("t6_beat_wr", int'(s_wr), 1);
    chk("t6_beat_owner", int'(s_owner), 1);
    bus.req = 4'b1000;
    cyc();
    chk("t6_drop_busy", int'(s_busy), 1);
    chk("t6_drop_wr", int'(s_wr), 0);
    cyc();
    chk("t6_bubble", int'(s_busy), 0);
    chk("t6_gnt3", int'(bus.gnt), 4'b1000);
    chk("t6_owner3", int'(bus.owner), 3);
    bus.req = 4'b0000;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
